// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine change/dispense controller:
// credit codes, upstream state codes and the controller state encoding.
package vend_pkg;

  localparam logic [3:0] Q_INVALID     = 4'd9;
  localparam logic [3:0] Q_MAX         = 4'd8;
  localparam logic [3:0] ST_WAIT_PULSE = 4'hF;
  localparam int         TMR_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DISPENSE,
    CHANGE,
    CLEAR
  } vend_state_t;

  // Change owed after a purchase, clamped so it can never wrap negative.
  function automatic logic [3:0] change_due(input logic [3:0] credit, input logic [3:0] price);
    return (credit > price) ? (credit - price) : 4'd0;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter; o_done is high on the last cycle of a loaded phase,
// so loading N-1 yields a phase exactly N cycles long.
module vend_pulse_timer
  import vend_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/vend_change_ctrl.sv
// Purchase/refund sequencer: latches buy/cancel edges, validates the settled credit,
// releases the product and pays change as timed quarter pulses, then clears the accumulator.
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_Q   = 6,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val_tot,
  input  logic [3:0] state_now,
  input  logic       buy,
  input  logic       cancel,
  output logic       dispense,
  output logic       change_pulse,
  output logic       clr_credit,
  output logic       busy,
  output logic       short_funds,
  output logic       err_invalid,
  output logic [3:0] change_left
);

  localparam logic [3:0]       LP_PRICE     = 4'(PRICE_Q);
  localparam logic [TMR_W-1:0] LP_PULSE_LEN = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LP_GAP_LEN   = TMR_W'(GAP_CYC - 1);

  vend_state_t      r_state;
  logic             r_buy_d;
  logic             r_cancel_d;
  logic             r_pend_buy;
  logic             r_pend_cancel;
  logic             r_is_cancel;
  logic             r_gap;
  logic [3:0]       r_credit;
  logic             w_buy_edge;
  logic             w_cancel_edge;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_len;
  logic             w_tmr_done;

  assign w_buy_edge    = buy & ~r_buy_d;
  assign w_cancel_edge = cancel & ~r_cancel_d;

  // The timer is armed in CHECK for whichever pulse follows, then re-armed at each phase end.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_len  = LP_PULSE_LEN;
    case (r_state)
      CHECK:    w_tmr_load = 1'b1;
      DISPENSE: w_tmr_load = w_tmr_done;
      CHANGE: begin
        w_tmr_load = w_tmr_done;
        w_tmr_len  = r_gap ? LP_PULSE_LEN : LP_GAP_LEN;
      end
      default: ;
    endcase
  end

  vend_pulse_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_tmr_load),
    .i_len (w_tmr_len),
    .o_done(w_tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_buy_d       <= 1'b0;
      r_cancel_d    <= 1'b0;
      r_pend_buy    <= 1'b0;
      r_pend_cancel <= 1'b0;
      r_is_cancel   <= 1'b0;
      r_gap         <= 1'b0;
      r_credit      <= 4'd0;
      dispense      <= 1'b0;
      change_pulse  <= 1'b0;
      clr_credit    <= 1'b0;
      busy          <= 1'b0;
      short_funds   <= 1'b0;
      err_invalid   <= 1'b0;
      change_left   <= 4'd0;
    end else begin
      r_buy_d     <= buy;
      r_cancel_d  <= cancel;
      clr_credit  <= 1'b0;
      short_funds <= 1'b0;
      err_invalid <= 1'b0;
      if (w_buy_edge && !busy)    r_pend_buy    <= 1'b1;
      if (w_cancel_edge && !busy) r_pend_cancel <= 1'b1;

      case (r_state)
        IDLE: begin
          // Credit is only trusted once the accumulator has settled.
          if ((r_pend_buy || r_pend_cancel) && (state_now != ST_WAIT_PULSE)) begin
            r_credit      <= val_tot;
            r_is_cancel   <= r_pend_cancel;
            r_pend_buy    <= 1'b0;
            r_pend_cancel <= 1'b0;
            busy          <= 1'b1;
            r_state       <= CHECK;
          end
        end
        CHECK: begin
          if (r_credit > Q_MAX) begin
            err_invalid <= 1'b1;
            clr_credit  <= 1'b1;
            r_state     <= CLEAR;
          end else if (r_is_cancel) begin
            change_left <= r_credit;
            if (r_credit != 4'd0) begin
              change_pulse <= 1'b1;
              r_gap        <= 1'b0;
              r_state      <= CHANGE;
            end else begin
              clr_credit <= 1'b1;
              r_state    <= CLEAR;
            end
          end else if (r_credit < LP_PRICE) begin
            short_funds <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else begin
            change_left <= change_due(r_credit, LP_PRICE);
            dispense    <= 1'b1;
            r_state     <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (w_tmr_done) begin
            dispense <= 1'b0;
            if (change_left != 4'd0) begin
              change_pulse <= 1'b1;
              r_gap        <= 1'b0;
              r_state      <= CHANGE;
            end else begin
              clr_credit <= 1'b1;
              r_state    <= CLEAR;
            end
          end
        end
        CHANGE: begin
          if (w_tmr_done) begin
            if (!r_gap) begin
              change_pulse <= 1'b0;
              change_left  <= change_left - 4'd1;
              r_gap        <= 1'b1;
            end else if (change_left == 4'd0) begin
              clr_credit <= 1'b1;
              r_state    <= CLEAR;
            end else begin
              change_pulse <= 1'b1;
              r_gap        <= 1'b0;
            end
          end
        end
        CLEAR: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: per-transaction event counts and timing
// are compared against a transaction-level model of the purchase/refund rules.
module tb_vend_change_ctrl;
  import vend_pkg::*;

  localparam int PRICE = 6;
  localparam int P     = 4;
  localparam int G     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] val_tot = 4'd0;
  logic [3:0] state_now = 4'd0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       dispense, change_pulse, clr_credit, busy, short_funds, err_invalid;
  logic [3:0] change_left;

  vend_change_ctrl #(.PRICE_Q(PRICE), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .val_tot     (val_tot),
    .state_now   (state_now),
    .buy         (buy),
    .cancel      (cancel),
    .dispense    (dispense),
    .change_pulse(change_pulse),
    .clr_credit  (clr_credit),
    .busy        (busy),
    .short_funds (short_funds),
    .err_invalid (err_invalid),
    .change_left (change_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running event totals; transactions compare deltas against the model.
  int   n_disp = 0, n_pulse = 0, n_clr = 0, n_short = 0, n_err = 0, n_busy = 0;
  int   n_overlap = 0, n_badw = 0, disp_rise_cyc = 0;
  int   run_len = 0, gap_len = 0;
  bit   in_gap = 0, prev_cp = 0, prev_disp = 0;
  logic [3:0] cl_at_rise [0:4095];

  always @(negedge clk) begin
    if (dispense) n_disp++;
    if (dispense && !prev_disp) disp_rise_cyc = cyc;
    if (change_pulse && !prev_cp) begin
      if (n_pulse < 4096) cl_at_rise[n_pulse] = change_left;
      n_pulse++;
      if (in_gap && gap_len != G) n_badw++;
      in_gap  = 0;
      run_len = 0;
    end
    if (change_pulse) run_len++;
    if (!change_pulse && prev_cp) begin
      if (run_len != P) n_badw++;
      in_gap  = 1;
      gap_len = 0;
    end
    if (in_gap && !change_pulse) gap_len++;
    if (!busy) in_gap = 0;
    if (dispense && change_pulse) n_overlap++;
    if (clr_credit) n_clr++;
    if (short_funds) n_short++;
    if (err_invalid) n_err++;
    if (busy) n_busy++;
    prev_cp   = change_pulse;
    prev_disp = dispense;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // op: 0 = buy, 1 = cancel, 2 = buy and cancel together (cancel wins).
  function automatic void model(input int val, input int op,
                                output int e_disp, output int e_pulse, output int e_clr,
                                output int e_short, output int e_err, output int e_busy);
    e_disp = 0; e_pulse = 0; e_clr = 0; e_short = 0; e_err = 0; e_busy = 0;
    if (val == int'(Q_INVALID)) begin
      e_err = 1; e_clr = 1; e_busy = 2;
    end else if (op != 0) begin
      e_pulse = val; e_clr = 1; e_busy = 2 + val * (P + G);
    end else if (val < PRICE) begin
      e_short = 1; e_busy = 1;
    end else begin
      e_disp = P; e_pulse = val - PRICE; e_clr = 1;
      e_busy = 2 + P + e_pulse * (P + G);
    end
  endfunction

  task automatic run_txn(input string name, input int val, input int w, input int op, input bit poke,
                         input int e_disp, input int e_pulse, input int e_clr,
                         input int e_short, input int e_err, input int e_busy);
    int s_disp, s_pulse, s_clr, s_short, s_err, s_busy, s_ovl, s_badw, t0, cl_ok, lat;
    bit started, done_ok;
    s_disp = n_disp; s_pulse = n_pulse; s_clr = n_clr; s_short = n_short;
    s_err = n_err; s_busy = n_busy; s_ovl = n_overlap; s_badw = n_badw;
    @(negedge clk); #1;
    val_tot   = 4'(val);
    state_now = (w > 0) ? ST_WAIT_PULSE : 4'h3;
    buy       = (op != 1);
    cancel    = (op != 0);
    t0        = cyc;
    started   = 0;
    done_ok   = 0;
    for (int i = 1; i <= 400 && !done_ok; i++) begin
      @(negedge clk); #1;
      if (i == w) state_now = 4'h3;
      if (i == 2) begin buy = 0; cancel = 0; end
      if (i == w + 4) val_tot = 4'($urandom_range(0, 9));
      if (poke && i == w + 6) cancel = 1;
      if (poke && i == w + 8) cancel = 0;
      if (busy) started = 1;
      else if (started) done_ok = 1;
    end
    buy = 0; cancel = 0;
    repeat (3) @(negedge clk);
    #1;
    check($sformatf("%s.completed", name), int'(done_ok), 1);
    check($sformatf("%s.dispense_cycles", name), n_disp - s_disp, e_disp);
    check($sformatf("%s.change_pulses", name), n_pulse - s_pulse, e_pulse);
    check($sformatf("%s.clr_credit", name), n_clr - s_clr, e_clr);
    check($sformatf("%s.short_funds", name), n_short - s_short, e_short);
    check($sformatf("%s.err_invalid", name), n_err - s_err, e_err);
    check($sformatf("%s.busy_cycles", name), n_busy - s_busy, e_busy);
    check($sformatf("%s.overlap", name), n_overlap - s_ovl, 0);
    check($sformatf("%s.pulse_widths", name), n_badw - s_badw, 0);
    check($sformatf("%s.change_left_end", name), int'(change_left), 0);
    if (e_disp > 0) begin
      lat = (w + 2 > 3) ? w + 2 : 3;
      check($sformatf("%s.latency", name), disp_rise_cyc - t0, lat);
    end
    if (e_pulse > 0) begin
      cl_ok = 0;
      for (int k = 0; k < e_pulse; k++)
        if (s_pulse + k < n_pulse && int'(cl_at_rise[s_pulse + k]) == e_pulse - k) cl_ok++;
      check($sformatf("%s.change_left_seq", name), cl_ok, e_pulse);
    end
    $display("txn %s val=%0d wait=%0d op=%0d disp=%0d pulses=%0d clr=%0d busy=%0d",
             name, val, w, op, n_disp - s_disp, n_pulse - s_pulse, n_clr - s_clr, n_busy - s_busy);
  endtask

  typedef struct {
    int val;
    int w;
    int op;
    bit poke;
    int e_disp;
    int e_pulse;
    int e_clr;
    int e_short;
    int e_err;
    int e_busy;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ed, ep, ec, es, ee, eb, val, w, op, s_pulse, s_disp, s_clr, s_busy;
    bit found;

    vecs[0] = '{8, 0, 0, 0, 4, 2, 1, 0, 0, 22};  // purchase with 2 quarters change
    vecs[1] = '{6, 0, 0, 0, 4, 0, 1, 0, 0, 6};   // exact price
    vecs[2] = '{4, 0, 0, 0, 0, 0, 0, 1, 0, 1};   // insufficient credit
    vecs[3] = '{8, 3, 0, 0, 4, 2, 1, 0, 0, 22};  // credit settles 3 cycles after buy
    vecs[4] = '{5, 0, 2, 0, 0, 5, 1, 0, 0, 42};  // buy+cancel together: refund
    vecs[5] = '{9, 0, 0, 0, 0, 0, 1, 0, 1, 2};   // invalid credit
    vecs[6] = '{7, 0, 0, 1, 4, 1, 1, 0, 0, 14};  // cancel edge during busy ignored
    vecs[7] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 2};   // refund of zero credit
    vecs[8] = '{3, 0, 1, 0, 0, 3, 1, 0, 0, 26};  // refund of 3

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          int'({dispense, change_pulse, clr_credit, busy, short_funds, err_invalid, change_left}), 0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++)
      run_txn($sformatf("vec%0d", k), vecs[k].val, vecs[k].w, vecs[k].op, vecs[k].poke,
              vecs[k].e_disp, vecs[k].e_pulse, vecs[k].e_clr, vecs[k].e_short,
              vecs[k].e_err, vecs[k].e_busy);

    for (int k = 0; k < 25; k++) begin
      val = int'($urandom_range(0, 9));
      w   = int'($urandom_range(0, 4));
      op  = int'($urandom_range(0, 2));
      model(val, op, ed, ep, ec, es, ee, eb);
      run_txn($sformatf("rand%0d", k), val, w, op, 0, ed, ep, ec, es, ee, eb);
    end

    // Reset asserted during the second change pulse of a purchase.
    s_pulse = n_pulse;
    found   = 0;
    @(negedge clk); #1;
    val_tot = 4'd8; state_now = 4'h3; buy = 1;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk); #1;
      if (i == 2) buy = 0;
      if (n_pulse >= s_pulse + 2) found = 1;
    end
    buy = 0;
    check("rst_mid.reached_2nd_pulse", int'(found), 1);
    rst = 1;
    #1;
    check("rst_mid.outputs_zero",
          int'({dispense, change_pulse, clr_credit, busy, short_funds, err_invalid, change_left}), 0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 0;
    s_pulse = n_pulse; s_disp = n_disp; s_clr = n_clr; s_busy = n_busy;
    repeat (30) @(negedge clk);
    #1;
    check("rst_mid.no_pulses_after", n_pulse - s_pulse, 0);
    check("rst_mid.no_dispense_after", n_disp - s_disp, 0);
    check("rst_mid.no_clr_after", n_clr - s_clr, 0);
    check("rst_mid.idle_after", n_busy - s_busy, 0);
    $display("txn rst_mid pulses_before_reset=%0d", 2);

    run_txn("post_rst", 8, 0, 0, 0, 4, 2, 1, 0, 0, 22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
